// File: rtl/a51_burst_xor.sv
// Burst cipher stage: drops the a51 warm-up bits, captures one burst of keystream,
// and XORs it onto a single data burst handed over through valid/ready handshakes.
module a51_burst_xor #(
  parameter int BURST_LEN   = 114,
  parameter int DISCARD_LEN = 100,
  parameter int CNT_W       = 7
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 ks_bit_i,
  input  logic                 ks_valid_i,
  input  logic [BURST_LEN-1:0] data_in_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic [BURST_LEN-1:0] data_out_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DISCARD   = 3'd1;
  localparam logic [2:0] S_COLLECT   = 3'd2;
  localparam logic [2:0] S_WAIT_DATA = 3'd3;
  localparam logic [2:0] S_OUTPUT    = 3'd4;

  // With no warm-up bits the DISCARD state is never entered, so its terminal count is moot.
  localparam logic [2:0]       FIRST_KS_STATE = (DISCARD_LEN == 0) ? S_COLLECT : S_DISCARD;
  localparam logic [CNT_W-1:0] DISC_LAST      = CNT_W'((DISCARD_LEN > 0) ? DISCARD_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] BURST_LAST     = CNT_W'(BURST_LEN - 1);

  logic [2:0]           state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [BURST_LEN-1:0] ks_buf_q,    ks_buf_d;
  logic [BURST_LEN-1:0] data_out_q,  data_out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q,      done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ks_buf_d    = ks_buf_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = FIRST_KS_STATE;
          cnt_d   = '0;
        end
      end
      S_DISCARD: begin
        if (ks_valid_i) begin
          if (cnt_q == DISC_LAST) begin
            state_d = S_COLLECT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_COLLECT: begin
        // Shift in from the bottom so the first collected bit lands in the MSB.
        if (ks_valid_i) begin
          ks_buf_d = {ks_buf_q[BURST_LEN-2:0], ks_bit_i};
          if (cnt_q == BURST_LAST) begin
            state_d = S_WAIT_DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WAIT_DATA: begin
        if (data_valid_i) begin
          data_out_d  = data_in_i ^ ks_buf_q;
          out_valid_d = 1'b1;
          state_d     = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ks_buf_q    <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ks_buf_q    <= ks_buf_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Ready comes straight from the state register so no input can reach it combinationally.
  assign data_ready_o = (state_q == S_WAIT_DATA);
  assign busy_o       = (state_q != S_IDLE);
  assign data_out_o   = data_out_q;
  assign out_valid_o  = out_valid_q;
  assign done_o       = done_q;

endmodule
